data_bus_bridge: RTL and testbench



---
 rtl/data_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_data_bus_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the M-stage single-cycle data request into a
// two-phase (address, then data) bus transaction. The pipeline is held
// through cpu_stall until the access completes. The returned read word
// is held while other stall sources keep the M stage in place.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; a new cpu_en latches the request
// ADDR  | bus_req asserted from latched fields, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
// DONE  | access complete, cpu_rdata valid until the M stage advances
module data_bus_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_en,
    input  logic [DW/8-1:0] cpu_wen,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    input  logic            pipe_stall,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [1:0]      bus_size,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        req_wr;
    logic [1:0]  req_size;
    logic [1:0]  req_lo;
    logic        req_latch;
    logic        rdata_load;

    // The byte offset on the bus is implied by the strobes, so the CPU's
    // own low address bits are intentionally not used.
    logic        unused_addr_lo;
    assign unused_addr_lo = ^cpu_addr[1:0];

    // Decode the strobe pattern into write flag, transfer size and offset.
    always_comb begin
        req_wr   = |cpu_wen;
        req_size = 2'd2;
        req_lo   = 2'd0;
        case (cpu_wen)
            4'b0001: begin req_size = 2'd0; req_lo = 2'd0; end
            4'b0010: begin req_size = 2'd0; req_lo = 2'd1; end
            4'b0100: begin req_size = 2'd0; req_lo = 2'd2; end
            4'b1000: begin req_size = 2'd0; req_lo = 2'd3; end
            4'b0011: begin req_size = 2'd1; req_lo = 2'd0; end
            4'b1100: begin req_size = 2'd1; req_lo = 2'd2; end
            default: begin req_size = 2'd2; req_lo = 2'd0; end
        endcase
    end

    // Next-state logic and per-state controls.
    always_comb begin
        state_nxt  = state;
        req_latch  = 1'b0;
        rdata_load = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_en) begin
                    req_latch = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    // A flushed request still finishes on the bus, but its
                    // data is dropped and the FSM goes straight back to IDLE.
                    rdata_load = cpu_en & ~bus_wr;
                    state_nxt  = cpu_en ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!pipe_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured once on IDLE->ADDR so the bus sees stable
    // values no matter what the CPU does afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (req_latch) begin
            bus_wr    <= req_wr;
            bus_size  <= req_size;
            bus_addr  <= {cpu_addr[AW-1:2], req_lo};
            bus_wdata <= cpu_wdata;
        end
    end

    // Read data register, held through DONE and beyond until the next read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rdata <= '0;
        end else if (rdata_load) begin
            cpu_rdata <= bus_rdata;
        end
    end

    // Combinational so the stall is seen in the very cycle cpu_en rises.
    always_comb begin
        bus_req   = (state == ADDR);
        cpu_stall = cpu_en & (state != DONE);
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: a table of access vectors with
// hand-computed bus fields, plus hand-written flush, hold and reset cases.
module tb_data_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        pipe_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          addr_dly;
        int          data_dly;
        logic [31:0] rdata;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    data_bus_bridge #(.AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .pipe_stall  (pipe_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    // Starts in the IDLE cycle (just after a rising edge); returns at the
    // falling edge of the first DONE cycle.
    task automatic run_access(input vec_t v);
        cpu_en      = 1'b1;
        cpu_wen     = v.wen;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wdata;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        to_mid();
        chk("idle_stall", {31'd0, cpu_stall}, 32'd1);
        chk("idle_req", {31'd0, bus_req}, 32'd0);
        step();
        cpu_addr  = ~v.addr;
        cpu_wdata = ~v.wdata;
        for (int k = 0; k <= v.addr_dly; k++) begin
            bus_addr_ok = (k == v.addr_dly);
            bus_data_ok = (k != v.addr_dly);
            to_mid();
            chk("addr_req", {31'd0, bus_req}, 32'd1);
            chk("addr_wr", {31'd0, bus_wr}, {31'd0, v.exp_wr});
            chk("addr_size", {30'd0, bus_size}, {30'd0, v.exp_size});
            chk("addr_addr", bus_addr, v.exp_addr);
            chk("addr_wdata", bus_wdata, v.wdata);
            chk("addr_stall", {31'd0, cpu_stall}, 32'd1);
            step();
        end
        bus_addr_ok = 1'b0;
        for (int k = 0; k <= v.data_dly; k++) begin
            bus_data_ok = (k == v.data_dly);
            bus_rdata   = (k == v.data_dly) ? v.rdata : (32'hBAD0_0000 | k);
            to_mid();
            chk("data_req", {31'd0, bus_req}, 32'd0);
            chk("data_stall", {31'd0, cpu_stall}, 32'd1);
            step();
        end
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0BAD_F00D;
        if (!v.exp_wr) model_rdata = v.rdata;
        to_mid();
        chk("done_stall", {31'd0, cpu_stall}, 32'd0);
        chk("done_req", {31'd0, bus_req}, 32'd0);
        chk("done_rdata", cpu_rdata, model_rdata);
    endtask

    initial begin
        //          wen      addr          wdata         adly dly rdata         wr size exp_addr
        vecs[0]  = '{4'b0000, 32'h0000_1004, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0000_1004};
        vecs[1]  = '{4'b0100, 32'h0000_2000, 32'h00AB_0000, 2, 0, 32'h1111_1111, 1'b1, 2'd0, 32'h0000_2002};
        vecs[2]  = '{4'b1100, 32'h0000_3000, 32'h1234_0000, 0, 0, 32'h2222_2222, 1'b1, 2'd1, 32'h0000_3002};
        vecs[3]  = '{4'b1111, 32'h0000_3103, 32'hA5A5_A5A5, 0, 2, 32'h3333_3333, 1'b1, 2'd2, 32'h0000_3100};
        vecs[4]  = '{4'b0001, 32'h0000_4002, 32'h0000_0077, 0, 0, 32'h4444_4444, 1'b1, 2'd0, 32'h0000_4000};
        vecs[5]  = '{4'b0010, 32'h0000_4000, 32'h0000_6600, 1, 0, 32'h5555_5555, 1'b1, 2'd0, 32'h0000_4001};
        vecs[6]  = '{4'b1000, 32'h0000_4001, 32'h5500_0000, 0, 1, 32'h6666_6666, 1'b1, 2'd0, 32'h0000_4003};
        vecs[7]  = '{4'b0011, 32'h0000_4003, 32'h0000_BEEF, 0, 0, 32'h7777_7777, 1'b1, 2'd1, 32'h0000_4000};
        vecs[8]  = '{4'b0101, 32'h0000_4006, 32'h00CC_00DD, 0, 0, 32'h8888_8888, 1'b1, 2'd2, 32'h0000_4004};
        vecs[9]  = '{4'b0000, 32'h0000_5007, 32'hFFFF_FFFF, 1, 1, 32'h1234_5678, 1'b0, 2'd2, 32'h0000_5004};
        vecs[10] = '{4'b0000, 32'h0000_6000, 32'h0000_0000, 0, 0, 32'hCAFE_F00D, 1'b0, 2'd2, 32'h0000_6000};
        vecs[11] = '{4'b0000, 32'h0000_6004, 32'h0000_0000, 0, 0, 32'h0F0F_0F0F, 1'b0, 2'd2, 32'h0000_6004};

        rst         = 1'b0;
        cpu_en      = 1'b0;
        cpu_wen     = 4'b0000;
        cpu_addr    = 32'h0;
        cpu_wdata   = 32'h0;
        pipe_stall  = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        model_rdata = 32'h0;

        step();
        step();
        to_mid();
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_wr", {31'd0, bus_wr}, 32'd0);
        chk("rst_size", {30'd0, bus_size}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        rst = 1'b1;

        // Table: back-to-back accesses, each new request in the IDLE cycle
        // right after DONE.
        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i]);
            step();
        end

        // Read finishing while the M stage is held by other stall sources.
        run_access(vecs[10]);
        pipe_stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            bus_data_ok = 1'b1;
            bus_rdata   = 32'h5A5A_0000 | k;
            to_mid();
            chk("hold_stall", {31'd0, cpu_stall}, 32'd0);
            chk("hold_req", {31'd0, bus_req}, 32'd0);
            chk("hold_rdata", cpu_rdata, 32'hCAFE_F00D);
        end
        step();
        bus_data_ok = 1'b0;
        pipe_stall  = 1'b0;
        to_mid();
        chk("hold_last_stall", {31'd0, cpu_stall}, 32'd0);
        chk("hold_last_rdata", cpu_rdata, 32'hCAFE_F00D);
        step();
        run_access(vecs[11]);
        step();

        // Flush while in ADDR: request held until accepted, data discarded.
        cpu_en   = 1'b1;
        cpu_wen  = 4'b0000;
        cpu_addr = 32'h0000_7000;
        step();
        cpu_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            to_mid();
            chk("flush_req_held", {31'd0, bus_req}, 32'd1);
            chk("flush_addr", bus_addr, 32'h0000_7000);
            chk("flush_stall", {31'd0, cpu_stall}, 32'd0);
            step();
        end
        bus_addr_ok = 1'b1;
        to_mid();
        chk("flush_req_last", {31'd0, bus_req}, 32'd1);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h9999_9999;
        to_mid();
        chk("flush_data_req", {31'd0, bus_req}, 32'd0);
        step();
        bus_data_ok = 1'b0;
        cpu_en      = 1'b1;
        to_mid();
        chk("flush_idle_probe", {31'd0, cpu_stall}, 32'd1);
        chk("flush_rdata", cpu_rdata, model_rdata);
        cpu_en = 1'b0;
        step();
        to_mid();
        chk("flush_no_req", {31'd0, bus_req}, 32'd0);
        step();

        // Reset while in DATA abandons the access.
        cpu_en    = 1'b1;
        cpu_wen   = 4'b1111;
        cpu_addr  = 32'h0000_8000;
        cpu_wdata = 32'h55AA_55AA;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        rst         = 1'b0;
        cpu_en      = 1'b0;
        to_mid();
        chk("pre_rst_wr", {31'd0, bus_wr}, 32'd1);
        chk("pre_rst_rdata", cpu_rdata, model_rdata);
        step();
        bus_data_ok = 1'b1;
        to_mid();
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_wr", {31'd0, bus_wr}, 32'd0);
        chk("mid_rst_size", {30'd0, bus_size}, 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_wdata", bus_wdata, 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'd0);
        step();
        rst = 1'b1;
        step();
        bus_data_ok = 1'b0;
        to_mid();
        chk("post_rst_req", {31'd0, bus_req}, 32'd0);
        chk("post_rst_rdata", cpu_rdata, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
